// File: rtl/alarm_buzz.sv
// Alarm comparator and buzzer driver for a min:sec clock: stores the alarm time,
// rings on a fresh match and drives a gated square wave until stopped or timed out.
module alarm_buzz #(
    parameter int CLK_HZ   = 50000000,
    parameter int TONE_HZ  = 1000,
    parameter int RING_SEC = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic       i_alarm_en,
    input  logic       i_inc_min,
    input  logic       i_inc_sec,
    input  logic       i_stop,
    output logic [5:0] o_alarm_min,
    output logic [5:0] o_alarm_sec,
    output logic       o_ringing,
    output logic       o_buzz
);

    localparam int TONE_HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int GATE_HALF = CLK_HZ / 2;

    localparam int PRESC_W = (CLK_HZ > 1)    ? $clog2(CLK_HZ)    : 1;
    localparam int SEC_W   = (RING_SEC > 1)  ? $clog2(RING_SEC)  : 1;
    localparam int TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int GATE_W  = (GATE_HALF > 1) ? $clog2(GATE_HALF) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(RING_SEC - 1);
    localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_HALF - 1);
    localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_HALF - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RING = 1'b1;

    logic [0:0]         state;
    logic [0:0]         next_state;
    logic               match;
    logic               match_q;
    logic               rise;
    logic               timeout;
    logic               leave;
    logic               ring_run;

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_nxt;
    logic [SEC_W-1:0]   sec_cnt;
    logic [SEC_W-1:0]   sec_cnt_nxt;
    logic [TONE_W-1:0]  tone_cnt;
    logic [TONE_W-1:0]  tone_cnt_nxt;
    logic               tone_q;
    logic               tone_nxt;
    logic [GATE_W-1:0]  gate_cnt;
    logic [GATE_W-1:0]  gate_cnt_nxt;
    logic               gate;
    logic               gate_nxt;

    // Alarm registers never exceed 59, so out-of-range time inputs cannot match.
    always_comb begin
        match    = i_alarm_en && (i_min == o_alarm_min) && (i_sec == o_alarm_sec);
        rise     = match && !match_q;
        timeout  = (presc == PRESC_LAST) && (sec_cnt == SEC_LAST);
        leave    = i_stop || !i_alarm_en || timeout;
        ring_run = (state == RING) && !leave;

        next_state = state;
        if (state == RING) begin
            if (leave) next_state = IDLE;
        end else if (rise) begin
            next_state = RING;
        end
    end

    // All timing counters restart from zero on RING entry and sit at zero in IDLE.
    always_comb begin
        presc_nxt    = '0;
        sec_cnt_nxt  = '0;
        tone_cnt_nxt = '0;
        tone_nxt     = 1'b0;
        gate_cnt_nxt = '0;
        gate_nxt     = (next_state == RING);
        if (ring_run) begin
            presc_nxt    = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            sec_cnt_nxt  = (presc == PRESC_LAST) ? sec_cnt + 1'b1 : sec_cnt;
            tone_cnt_nxt = (tone_cnt == TONE_LAST) ? '0 : tone_cnt + 1'b1;
            tone_nxt     = (tone_cnt == TONE_LAST) ? ~tone_q : tone_q;
            gate_cnt_nxt = (gate_cnt == GATE_LAST) ? '0 : gate_cnt + 1'b1;
            gate_nxt     = (gate_cnt == GATE_LAST) ? ~gate : gate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            match_q     <= 1'b0;
            o_alarm_min <= 6'd0;
            o_alarm_sec <= 6'd0;
            presc       <= '0;
            sec_cnt     <= '0;
            tone_cnt    <= '0;
            tone_q      <= 1'b0;
            gate_cnt    <= '0;
            gate        <= 1'b0;
            o_buzz      <= 1'b0;
        end else begin
            state    <= next_state;
            match_q  <= match;
            presc    <= presc_nxt;
            sec_cnt  <= sec_cnt_nxt;
            tone_cnt <= tone_cnt_nxt;
            tone_q   <= tone_nxt;
            gate_cnt <= gate_cnt_nxt;
            gate     <= gate_nxt;
            // Built from next-cycle values so the buzzer is already low on the exit edge.
            o_buzz   <= tone_nxt && gate_nxt && (next_state == RING);
            if (state == IDLE) begin
                if (i_inc_min) o_alarm_min <= (o_alarm_min == 6'd59) ? 6'd0 : o_alarm_min + 6'd1;
                if (i_inc_sec) o_alarm_sec <= (o_alarm_sec == 6'd59) ? 6'd0 : o_alarm_sec + 6'd1;
            end
        end
    end

    assign o_ringing = (state == RING);

endmodule

// File: doc/alarm_buzz.md
ALARM_BUZZ -- requirements
Module: alarm_buzz

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TONE_HZ, default 1000, buzzer tone frequency in Hz.
REQ-003 Parameter RING_SEC, default 30, maximum ring duration in seconds.
REQ-004 clk  input  1  system clock, rising-edge active.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_min  input  6  current clock minutes, 0..59, from the min:sec counter.
REQ-007 i_sec  input  6  current clock seconds, 0..59, from the min:sec counter.
REQ-008 i_alarm_en  input  1  alarm armed when 1, level.
REQ-009 i_inc_min  input  1  one-clk pulse (already debounced and edge-detected), alarm minute +1.
REQ-010 i_inc_sec  input  1  one-clk pulse (already debounced and edge-detected), alarm second +1.
REQ-011 i_stop  input  1  one-clk pulse, silences a ringing alarm.
REQ-012 o_alarm_min  output  6  stored alarm minute, 0..59.
REQ-013 o_alarm_sec  output  6  stored alarm second, 0..59.
REQ-014 o_ringing  output  1  1 while in RING state.
REQ-015 o_buzz  output  1  square-wave drive for the piezo buzzer.

Function
REQ-016 Alarm set: in IDLE, i_inc_min steps o_alarm_min 0→59→0 and i_inc_sec steps o_alarm_sec 0→59→0, both on the next clk edge, with no carry between the two fields.
REQ-017 Simultaneous i_inc_min and i_inc_sec SHALL both apply in the same cycle.
REQ-018 i_inc_min and i_inc_sec SHALL be ignored in RING.
REQ-019 match = i_alarm_en & (i_min==o_alarm_min) & (i_sec==o_alarm_sec); match_q is match registered every cycle.
REQ-020 FSM states: IDLE, RING, 1-bit registered state.
REQ-021 IDLE→RING on the edge where match=1 and match_q=0; o_ringing rises 1 clk after the inputs first match.
REQ-022 A match held steady after a stop or timeout SHALL NOT retrigger; a new 0→1 match edge is required.
REQ-023 RING→IDLE on the first of: i_stop=1, i_alarm_en=0, or ring timer reaching RING_SEC seconds.
REQ-024 On simultaneous exit and rearm conditions, exit wins.
REQ-025 Ring timer: 1 s prescaler counting CLK_HZ clks, plus a seconds counter; both are cleared on RING entry and held at 0 in IDLE; the timeout fires exactly RING_SEC*CLK_HZ clks after RING entry.
REQ-026 Tone: half-period counter of CLK_HZ/(2*TONE_HZ) clks toggles tone_q; the counter and tone_q are cleared in IDLE.
REQ-027 Cadence: gate toggles every CLK_HZ/2 clks in RING, is 1 on RING entry, and is cleared in IDLE (0.5 s beep / 0.5 s silence).
REQ-028 o_buzz = tone_q & gate & (state==RING), registered, and SHALL be 0 in IDLE.
REQ-029 Counter widths SHALL be sized by $clog2 of their terminal counts, with no truncation for the default parameters.
REQ-030 Inputs i_min/i_sec values >59 SHALL NOT cause a match with the valid alarm registers, and SHALL NOT cause any other side effect.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, o_alarm_min=0, o_alarm_sec=0, match_q=0, o_ringing=0, o_buzz=0, and all counters, tone_q and gate=0.
REQ-032 Reset asserted during RING SHALL silence o_buzz immediately, without waiting for a clk edge.
REQ-033 After reset release, if match=1 on the first clk, RING SHALL be entered, since match_q is reset to 0.

Verification (CLK_HZ=20, TONE_HZ=5, RING_SEC=3)
REQ-034 Set: 61 i_inc_min pulses and 2 i_inc_sec pulses → o_alarm_min=1, o_alarm_sec=2; one simultaneous pulse on both → 2/3.
REQ-035 Trigger: alarm 00:05, en=1, i_sec steps 4→5 → o_ringing=1 one clk later; o_buzz toggles every 2 clks for the first 10 clks, then is 0 for 10 clks.
REQ-036 Timeout: no stop → o_ringing falls exactly 60 clks after rising; i_sec held at 5 → no retrigger.
REQ-037 Stop/disable: i_stop pulse at clk 7 of RING → IDLE next edge, o_buzz=0; repeat with i_alarm_en dropped → same result; i_inc_sec during RING → o_alarm_sec unchanged.
REQ-038 Reset mid-ring: rst_n low at clk 15 of RING → o_buzz=0 and o_ringing=0 asynchronously, alarm registers=0.
REQ-039 Disarmed: en=0 and times match → o_ringing stays 0; en raised while match holds → RING next clk.
